// File: rtl/mem_copy_dma.sv
// Word-granular block copy engine. It owns the data-memory port while busy and
// moves one word per READ/WRITE cycle pair, in ascending address order.
module mem_copy_dma #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_wd,
  output logic             mem_we,
  input  logic [31:0]      mem_rd
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] WORD_BYTES = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DW-1:0]    buf_q, buf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [AW-1:0]    mem_address_q, mem_address_d;
  logic [DW-1:0]    mem_wd_q, mem_wd_d;
  logic             mem_we_q, mem_we_d;

  // Next state and transfer bookkeeping.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = word_count;
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            state_d = S_ERR;
          end else if (word_count == CNT_W'(0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        buf_d   = mem_rd;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        src_d = src_q + WORD_BYTES;
        dst_d = dst_q + WORD_BYTES;
        if (rem_q != CNT_W'(0)) begin
          rem_d = rem_q - CNT_W'(1);
        end
        state_d = (rem_q <= CNT_W'(1)) ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they leave a flop each cycle.
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    error_d       = (state_d == S_ERR);
    mem_we_d      = (state_d == S_WRITE);
    mem_address_d = AW'(0);
    mem_wd_d      = DW'(0);
    if (state_d == S_READ) begin
      mem_address_d = src_d;
    end else if (state_d == S_WRITE) begin
      mem_address_d = dst_d;
      mem_wd_d      = buf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      src_q         <= AW'(0);
      dst_q         <= AW'(0);
      rem_q         <= CNT_W'(0);
      buf_q         <= DW'(0);
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      mem_address_q <= AW'(0);
      mem_wd_q      <= DW'(0);
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      rem_q         <= rem_d;
      buf_q         <= buf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      mem_address_q <= mem_address_d;
      mem_wd_q      <= mem_wd_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign mem_address = mem_address_q;
  assign mem_wd      = mem_wd_q;
  assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: a 64-word combinational-read memory beside the DUT and
// a reference array updated by a plain ascending word-copy loop.
module tb_mem_copy_dma;

  localparam int unsigned CNT_W = 7;
  localparam int unsigned NW    = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy;
  logic             done;
  logic             error;
  logic [31:0]      mem_address;
  logic [31:0]      mem_wd;
  logic             mem_we;
  logic [31:0]      mem_rd;

  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .mem_address(mem_address),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  // Data memory: byte addresses alias modulo 256, read is combinational.
  assign mem_rd = mem[6'(mem_address >> 2)];
  always @(posedge clk) if (mem_we) mem[6'(mem_address >> 2)] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w]     = v;
    ref_mem[w] = v;
  endtask

  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++)
      ref_mem[6'((d >> 2) + 32'(i))] = ref_mem[6'((s >> 2) + 32'(i))];
  endtask

  task automatic check_mem();
    for (int w = 0; w < int'(NW); w++)
      check($sformatf("mem[%0d]", w), mem[w], ref_mem[w]);
  endtask

  // Issue one start and follow the transfer cycle by cycle until done/error.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit poke);
    int done_k  = 0;
    int err_k   = 0;
    int we_n    = 0;
    int busy_lo = 0;
    bit bad     = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    src_addr   = s;
    dst_addr   = d;
    word_count = CNT_W'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    src_addr   = $urandom;
    dst_addr   = $urandom;
    word_count = CNT_W'($urandom);
    for (int k = 1; k <= 2 * n + 6; k++) begin
      if (!busy)  busy_lo++;
      if (mem_we) we_n++;
      if (error) begin err_k = k; break; end
      if (done)  begin done_k = k; break; end
      if (poke && k == 3) begin
        start      = 1'b1;
        src_addr   = $urandom & 32'hFFFF_FFFC;
        dst_addr   = $urandom & 32'hFFFF_FFFC;
        word_count = CNT_W'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_low_in_xfer", busy_lo, 0);
    check("done_cycle", done_k, bad ? 0 : 2 * n + 1);
    check("error_cycle", err_k, bad ? 1 : 0);
    check("we_cycles", we_n, bad ? 0 : n);
    check("addr_at_end", mem_address, 32'h0);
    check("we_at_end", {31'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    check("busy_after", {31'b0, busy}, 32'h0);
    check("done_after", {31'b0, done}, 32'h0);
    if (!bad) model_copy(s, d, n);
    check_mem();
  endtask

  initial begin
    logic [31:0] s, d;
    reset      = 1'b0;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;
    for (int w = 0; w < int'(NW); w++) set_word(w, $urandom);
    #12;
    check("rst_busy",  {31'b0, busy},   32'h0);
    check("rst_done",  {31'b0, done},   32'h0);
    check("rst_error", {31'b0, error},  32'h0);
    check("rst_we",    {31'b0, mem_we}, 32'h0);
    check("rst_addr",  mem_address,     32'h0);
    check("rst_wd",    mem_wd,          32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word copy.
    set_word(0, 32'h1111_1111); set_word(1, 32'h2222_2222);
    set_word(2, 32'h3333_3333); set_word(3, 32'h4444_4444);
    run_copy(32'h0, 32'h80, 4, 1'b0);
    check("copy4_w32", mem[32], 32'h1111_1111);
    check("copy4_w35", mem[35], 32'h4444_4444);
    check("copy4_src0", mem[0], 32'h1111_1111);

    run_copy(32'h40, 32'h20, 0, 1'b0);
    run_copy(32'h02, 32'h40, 3, 1'b0);
    run_copy(32'h00, 32'h41, 3, 1'b0);
    run_copy(32'h00, 32'hC0, 8, 1'b1);

    // Overlapping regions in both directions.
    set_word(0, 32'hAAAA_0001); set_word(1, 32'hBBBB_0002);
    set_word(2, 32'hCCCC_0003); set_word(3, 32'hDDDD_0004);
    run_copy(32'h00, 32'h04, 3, 1'b0);
    check("ovl_up_w1", mem[1], 32'hAAAA_0001);
    check("ovl_up_w3", mem[3], 32'hAAAA_0001);
    set_word(0, 32'hAAAA_0001); set_word(1, 32'hBBBB_0002);
    set_word(2, 32'hCCCC_0003); set_word(3, 32'hDDDD_0004);
    run_copy(32'h04, 32'h00, 3, 1'b0);
    check("ovl_dn_w0", mem[0], 32'hBBBB_0002);
    check("ovl_dn_w2", mem[2], 32'hDDDD_0004);

    // Source address wrapping past 0xFFFFFFFC.
    run_copy(32'hFFFF_FFF8, 32'h40, 4, 1'b0);

    // Reset during the second WRITE of a 5-word copy: only word 0 lands.
    src_addr = 32'h0; dst_addr = 32'h80; word_count = CNT_W'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("we_before_reset", {31'b0, mem_we}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy},   32'h0);
    check("mid_rst_we",   {31'b0, mem_we}, 32'h0);
    check("mid_rst_addr", mem_address,     32'h0);
    check("mid_rst_wd",   mem_wd,          32'h0);
    model_copy(32'h0, 32'h80, 1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    run_copy(32'h10, 32'hC0, 1, 1'b0);

    // Randomized transfers, some misaligned, some with a stray start mid-flight.
    for (int t = 0; t < 25; t++) begin
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
      run_copy(s, d, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-granular copy engine that acts as the initiator on the data-memory port (address, write data, write enable, combinational read data), which the data memory answers as responder. On a start pulse it copies a block of 32-bit words from a source region to a destination region, one read cycle and one write cycle per word. It sits beside the processor and takes over the data-memory port while busy; the top level muxes the port on `busy`.

## Interface
- `CNT_W`, 7: width of `word_count`; allows 0..2^CNT_W−1 words (default covers the full 64-word data memory).
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `src_addr`  in  32  byte address of first source word.
- `dst_addr`  in  32  byte address of first destination word.
- `word_count`  in  CNT_W  number of words to copy.
- `busy`  out  1  high from the cycle after an accepted start until the cycle after done.
- `done`  out  1  one-cycle pulse at transfer completion.
- `error`  out  1  one-cycle pulse: start rejected for misalignment.
- `mem_address`  out  32  byte address to data memory.
- `mem_wd`  out  32  write data to data memory.
- `mem_we`  out  1  write enable to data memory.
- `mem_rd`  in  32  combinational read data from data memory.

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: `start`=1 latches src/dst/count into internal registers.
  - `src_addr[1:0]`≠0 or `dst_addr[1:0]`≠0 → ERR (no memory access).
  - else `word_count`=0 → DONE (no memory access).
  - else → READ.
- READ: `mem_address`=current src, `mem_we`=0; `mem_rd` captured into 32-bit buffer at clock edge → WRITE.
- WRITE: `mem_address`=current dst, `mem_wd`=buffer, `mem_we`=1; at edge src+=4, dst+=4, remaining−=1; remaining reaches 0 → DONE, else → READ.
- DONE: `done`=1 for this cycle → IDLE.
- ERR: `error`=1 for this cycle → IDLE.
- Address arithmetic: 32-bit, wraps modulo 2^32 (0xFFFFFFFC+4 = 0x00000000). Remaining counter is CNT_W bits and never underflows.
- Copy is always ascending. Overlap with dst>src within the block propagates already-copied words (defined behaviour, not an error); dst≤src copies correctly.
- `start` outside IDLE is ignored; input address/count changes after acceptance have no effect.
- `busy` high in READ, WRITE, DONE, ERR; low in IDLE.
- In IDLE, DONE, ERR: `mem_address`=0, `mem_wd`=0, `mem_we`=0.

## Timing
- Reset (asserted low, asynchronous): state=IDLE, `busy`=0, `done`=0, `error`=0, `mem_we`=0, `mem_address`=0, `mem_wd`=0, internal registers cleared. Takes effect immediately, including mid-transfer; a write in progress at that cycle is not committed unless the clock edge precedes the reset assertion.
- Start accepted at edge E0; first READ cycle follows E0.
- N words: 2N cycles of READ/WRITE, then one DONE cycle; `done` high in cycle 2N+1 after acceptance; next start accepted on the edge ending DONE+1 (IDLE).
- Zero-count and error cases: `done`/`error` in the first cycle after acceptance.
- `mem_we` is high only in WRITE cycles, exactly N cycles per transfer.
- Memory write commits on the edge ending each WRITE cycle; read data is used within the same READ cycle (combinational memory read).

## Test plan
- Copy 4 words, src=0x00, dst=0x80, memory words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 → words 32..35 hold same values; `mem_we` high exactly 4 cycles; `done` in cycle 9 after start; source unchanged.
- `word_count`=0, start → `done` in cycle 1, `mem_we` never asserted, memory unchanged.
- src=0x02, dst=0x40, count=3 → `error` pulse in cycle 1, no `done`, `mem_we` never asserted; same with dst=0x41.
- Start during transfer (count=8) with different src/dst → ignored; original transfer completes unchanged, single `done`.
- Overlap src=0x00, dst=0x04, count=3, words 0..3 = A, B, C, D → words 1..3 = A, A, A; and src=0x04, dst=0x00 → words 0..2 = B, C, D.
- Reset asserted low during WRITE of word 2 of 5 → outputs zero immediately, `busy`=0; after release a new 1-word start copies correctly with `done` in cycle 3.
